board_input_ctrl: RTL and testbench

Memory-mapped input peripheral that sits inside the Qsys system between the DE-board switches/push-buttons and the PULPino core, i.e. the receiving end of the KEY/SW stimulus a bench drives. It synchronizes and debounces SW[9:0] and KEY[3:1] and reports the debounced state. It latches change events in sticky flags and raises a maskable interrupt. The core reads and clears these through an Avalon-MM slave port with fixed read latency 1.

---
 rtl/board_input_ctrl_if.sv | 24 ++
 rtl/board_input_ctrl.sv | 133 +++++++++++++
 tb/tb_board_input_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/board_input_ctrl_if.sv
// rtl/board_input_ctrl_if.sv - Avalon-MM register port of board_input_ctrl (fixed read latency 1)
interface board_input_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/board_input_ctrl.sv
// rtl/board_input_ctrl.sv - switch/button synchronizer, tick debouncer, sticky edge flags and IRQ
module board_input_ctrl #(
    parameter int NSW       = 10,
    parameter int NKEY      = 3,
    parameter int DIV_RESET = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NSW-1:0]      sw_in,
    input  logic [NKEY-1:0]     key_in,
    board_input_ctrl_if.slave   bus,
    output logic                irq
);
    localparam int NIN = NSW + NKEY;
    localparam logic [15:0]    DIV_INIT = 16'(DIV_RESET);
    localparam logic [NIN-1:0] SYNC_RST = {{NKEY{1'b1}}, {NSW{1'b0}}};
    localparam logic [NIN-1:0] SW_BITS  = {{NKEY{1'b0}}, {NSW{1'b1}}};
    localparam logic [NIN-1:0] KEY_BITS = {{NKEY{1'b1}}, {NSW{1'b0}}};

    // Synchronizers carry raw pin levels; key polarity is flipped after them.
    logic [NIN-1:0]      r_sync1;
    logic [NIN-1:0]      r_sync2;
    logic [NIN-1:0]      w_sync;
    logic [15:0]         r_div;
    logic [15:0]         r_presc;
    logic                w_tick;
    logic [NIN-1:0][1:0] r_sc;
    logic [NIN-1:0]      r_db;
    logic [NIN-1:0]      r_db_d;
    logic [NIN-1:0]      r_edge;
    logic [NIN-1:0]      r_mask;
    logic [31:0]         r_rdata;
    logic [31:0]         w_rdata;
    logic                w_wr_edge;
    logic                w_wr_mask;
    logic                w_wr_div;
    logic [NIN-1:0]      w_edge_set;
    logic [NIN-1:0]      w_edge_clr;
    logic                w_unused_wdata;

    assign w_sync = {~r_sync2[NIN-1:NSW], r_sync2[NSW-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= SYNC_RST;
            r_sync2 <= SYNC_RST;
        end else begin
            r_sync1 <= {key_in, sw_in};
            r_sync2 <= r_sync1;
        end
    end

    assign w_wr_edge = bus.write && (bus.address == 2'd1);
    assign w_wr_mask = bus.write && (bus.address == 2'd2);
    assign w_wr_div  = bus.write && (bus.address == 2'd3);

    // A divider of 0 or 1 degenerates to a tick on every cycle.
    assign w_tick = (r_div <= 16'd1) || (r_presc == (r_div - 16'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= 16'd0;
        end else if (w_wr_div || w_tick) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Three consecutive ticks of disagreement are needed before db follows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sc <= '0;
            r_db <= '0;
        end else if (w_wr_div) begin
            r_sc <= '0;
        end else if (w_tick) begin
            for (int i = 0; i < NIN; i++) begin
                if (w_sync[i] == r_db[i]) begin
                    r_sc[i] <= 2'd0;
                end else if (r_sc[i] == 2'd2) begin
                    r_db[i] <= w_sync[i];
                    r_sc[i] <= 2'd0;
                end else begin
                    r_sc[i] <= r_sc[i] + 2'd1;
                end
            end
        end
    end

    assign w_edge_set = ((r_db ^ r_db_d) & SW_BITS) | (r_db & ~r_db_d & KEY_BITS);
    assign w_edge_clr = w_wr_edge ? bus.writedata[NIN-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db_d <= '0;
            r_edge <= '0;
            r_mask <= '0;
            r_div  <= DIV_INIT;
        end else begin
            r_db_d <= r_db;
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
            if (w_wr_mask) begin
                r_mask <= bus.writedata[NIN-1:0];
            end
            if (w_wr_div) begin
                r_div <= bus.writedata[15:0];
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus.address)
            2'd0:    w_rdata = {{(32-NIN){1'b0}}, r_db};
            2'd1:    w_rdata = {{(32-NIN){1'b0}}, r_edge};
            2'd2:    w_rdata = {{(32-NIN){1'b0}}, r_mask};
            default: w_rdata = {16'd0, r_div};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
        end else if (bus.read) begin
            r_rdata <= w_rdata;
        end
    end

    assign bus.readdata   = r_rdata;
    assign irq            = |(r_edge & r_mask);
    assign w_unused_wdata = ^bus.writedata[31:16];
endmodule

// File: tb/tb_board_input_ctrl.sv
// tb/tb_board_input_ctrl.sv - directed self-checking bench for board_input_ctrl
module tb_board_input_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  sw_in;
    logic [2:0]  key_in;
    logic        irq;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd;

    board_input_ctrl_if bus_if();

    board_input_ctrl #(.NSW(10), .NKEY(3), .DIV_RESET(50000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_in  (sw_in),
        .key_in (key_in),
        .bus    (bus_if),
        .irq    (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Each bus task starts and ends on a falling edge; the access lands on the rising edge in between.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        @(negedge clk);
        bus_if.write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.address = a;
        bus_if.read    = 1'b1;
        @(negedge clk);
        bus_if.read    = 1'b0;
        d = bus_if.readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n            = 1'b0;
        sw_in            = 10'h000;
        key_in           = 3'b111;
        bus_if.address   = 2'd0;
        bus_if.read      = 1'b0;
        bus_if.write     = 1'b0;
        bus_if.writedata = 32'd0;
        idle(3);
        rst_n = 1'b1;
        chk("reset_readdata", bus_if.readdata, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        bus_rd(2'd3, rd); chk("reset_debounce", rd, 32'd50000);

        bus_wr(2'd3, 32'd4);
        bus_rd(2'd0, rd); chk("init_data", rd, 32'h0);
        bus_rd(2'd1, rd); chk("init_edge", rd, 32'h0);
        bus_rd(2'd2, rd); chk("init_mask", rd, 32'h0);
        bus_rd(2'd3, rd); chk("init_div", rd, 32'd4);
        chk("init_irq", {31'd0, irq}, 32'h0);

        // Switch change: cannot appear before 11 cycles, must appear by 16.
        sw_in = 10'h201;
        idle(8);
        bus_rd(2'd0, rd); chk("sw_data_early", rd, 32'h0);
        idle(4);
        bus_rd(2'd0, rd); chk("sw_data_late", rd, 32'h201);
        bus_rd(2'd1, rd); chk("sw_edge", rd, 32'h201);
        chk("sw_irq_masked", {31'd0, irq}, 32'h0);
        idle(3);
        chk("readdata_hold", bus_if.readdata, 32'h201);
        bus_wr(2'd1, 32'h201);
        bus_rd(2'd1, rd); chk("edge_w1c", rd, 32'h0);
        bus_wr(2'd0, 32'h1FFF);
        bus_rd(2'd0, rd); chk("data_ro", rd, 32'h201);

        // Six-cycle glitch on key_in[1] is shorter than 2*DIV.
        key_in = 3'b101;
        idle(6);
        key_in = 3'b111;
        idle(20);
        bus_rd(2'd0, rd); chk("glitch_data", rd, 32'h201);
        bus_rd(2'd1, rd); chk("glitch_edge", rd, 32'h0);

        // Key press raises irq through the mask; release sets nothing.
        bus_wr(2'd2, 32'h400);
        key_in = 3'b110;
        idle(16);
        chk("key_irq", {31'd0, irq}, 32'h1);
        bus_rd(2'd1, rd); chk("key_edge", rd, 32'h400);
        bus_rd(2'd0, rd); chk("key_data", rd, 32'h601);
        bus_wr(2'd1, 32'h400);
        chk("key_irq_clr", {31'd0, irq}, 32'h0);
        key_in = 3'b111;
        idle(20);
        bus_rd(2'd1, rd); chk("release_edge", rd, 32'h0);
        bus_rd(2'd0, rd); chk("release_data", rd, 32'h201);
        chk("release_irq", {31'd0, irq}, 32'h0);

        // Same-cycle read and write returns the old value.
        @(negedge clk);
        bus_if.address   = 2'd2;
        bus_if.writedata = 32'h1FFF;
        bus_if.read      = 1'b1;
        bus_if.write     = 1'b1;
        @(negedge clk);
        bus_if.read      = 1'b0;
        bus_if.write     = 1'b0;
        chk("rw_old", bus_if.readdata, 32'h400);
        bus_rd(2'd2, rd); chk("rw_new", rd, 32'h1FFF);
        bus_wr(2'd2, 32'h0);
        chk("mask_zero_irq", {31'd0, irq}, 32'h0);

        // DEBOUNCE write aligns the prescaler: ticks act 4, 8, 12 edges later, flag sets on edge 13.
        bus_wr(2'd3, 32'd4);
        sw_in = 10'h203;
        idle(11);
        bus_wr(2'd1, 32'h002);
        bus_rd(2'd1, rd); chk("race_edge", rd, 32'h002);
        bus_rd(2'd0, rd); chk("race_data", rd, 32'h203);

        // Reset mid-debounce with irq pending.
        bus_wr(2'd2, 32'h002);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        sw_in = 10'h207;
        idle(5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_readdata", bus_if.readdata, 32'h0);
        bus_rd(2'd0, rd); chk("rst_data", rd, 32'h0);
        bus_rd(2'd1, rd); chk("rst_edge", rd, 32'h0);
        bus_rd(2'd2, rd); chk("rst_mask", rd, 32'h0);
        bus_rd(2'd3, rd); chk("rst_div", rd, 32'd50000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
